// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states
// and the iteration count of the sequential engine.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative engine: shift-add multiply or restoring divide, one bit
// per enabled step, over a single 64-bit working register.
module muldiv_iter_core
  import hilo_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic        i_is_div,
  input  logic [31:0] i_a_mag,
  input  logic [31:0] i_b_mag,
  output logic [63:0] o_work,
  output logic [31:0] o_rem,
  output logic [31:0] o_quot
);

  logic [63:0] r_work;
  logic [31:0] r_b;

  logic [32:0] w_add;
  logic [63:0] w_mul_next;
  logic [32:0] w_shift;
  logic [33:0] w_diff;
  logic [63:0] w_div_next;

  // Multiply: upper half accumulates the multiplicand, lower half holds the
  // remaining multiplier bits; the carry lands in bit 63 after the shift.
  // Divide: upper half is the partial remainder, lower half the dividend
  // being shifted out and replaced by quotient bits.
  always_comb begin
    w_add      = {1'b0, r_work[63:32]} + (r_work[0] ? {1'b0, r_b} : 33'd0);
    w_mul_next = {w_add, r_work[31:1]};
    w_shift    = {r_work[63:31]};
    w_diff     = {1'b0, w_shift} - {2'b00, r_b};
    w_div_next = w_diff[33] ? {w_shift[31:0], r_work[30:0], 1'b0}
                            : {w_diff[31:0], r_work[30:0], 1'b1};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_work <= '0;
      r_b    <= '0;
    end else if (i_load) begin
      r_work <= {32'd0, i_a_mag};
      r_b    <= i_b_mag;
    end else if (i_step) begin
      r_work <= i_is_div ? w_div_next : w_mul_next;
    end
  end

  assign o_work = r_work;
  assign o_rem  = r_work[63:32];
  assign o_quot = r_work[31:0];

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Owns the architectural HI/LO registers; sequences the iterative engine,
// applies result signs, accumulates MADD/MSUB and services mthi/mtlo.
module hilo_muldiv_unit
  import hilo_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MthiEn,
  input  logic        MtloEn,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi_OUT,
  output logic [31:0] Lo_OUT
);

  state_t      r_state, w_state_next;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic        r_neg_q, r_neg_r, r_bzero;
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  logic        w_start, w_sgn;
  logic [31:0] w_a_mag, w_b_mag;
  logic [63:0] w_work, w_prod_s, w_acc;
  logic [31:0] w_rem, w_quot, w_quot_s, w_rem_s;

  always_comb begin
    w_start = (r_state == S_IDLE) && Start && op_is_valid(Op);
    w_sgn   = op_is_signed(Op);
    w_a_mag = (w_sgn && A[31]) ? (~A + 32'd1) : A;
    w_b_mag = (w_sgn && B[31]) ? (~B + 32'd1) : B;
  end

  muldiv_iter_core u_core (
    .Clk      (Clk),
    .Rst      (Rst),
    .i_load   (w_start),
    .i_step   (r_state == S_RUN),
    .i_is_div (r_op[2]),
    .i_a_mag  (w_a_mag),
    .i_b_mag  (w_b_mag),
    .o_work   (w_work),
    .o_rem    (w_rem),
    .o_quot   (w_quot)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = S_RUN;
      S_RUN:    if (r_cnt == 5'(ITER - 1)) w_state_next = S_FINISH;
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Accumulation reads the live HI/LO here, so an mthi/mtlo issued with Start
  // is already folded in.
  always_comb begin
    w_prod_s = r_neg_q ? (~w_work + 64'd1) : w_work;
    w_acc    = {r_hi, r_lo};
    w_quot_s = r_neg_q ? (~w_quot + 32'd1) : w_quot;
    w_rem_s  = r_neg_r ? (~w_rem + 32'd1) : w_rem;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == S_FINISH);
      if (w_start) begin
        r_op    <= Op;
        r_a     <= A;
        r_neg_q <= w_sgn && (A[31] ^ B[31]);
        r_neg_r <= w_sgn && A[31];
        r_bzero <= (B == 32'd0);
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 5'd1;
      end
      if (r_state == S_IDLE) begin
        if (MthiEn) r_hi <= WrData;
        if (MtloEn) r_lo <= WrData;
      end
      if (r_state == S_FINISH) begin
        case (r_op)
          OP_MULT, OP_MULTU: {r_hi, r_lo} <= w_prod_s;
          OP_MADD:           {r_hi, r_lo} <= w_acc + w_prod_s;
          OP_MSUB:           {r_hi, r_lo} <= w_acc - w_prod_s;
          OP_DIV, OP_DIVU: begin
            if (r_bzero) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else begin
              r_hi <= w_rem_s;
              r_lo <= w_quot_s;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy   = (r_state != S_IDLE);
  assign Done   = r_done;
  assign Hi_OUT = r_hi;
  assign Lo_OUT = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench: the stimulus thread pushes expected HI/LO from a plain
// arithmetic model; a monitor pops and compares on every Done pulse.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        MthiEn, MtloEn;
  logic [31:0] WrData;
  logic        Busy, Done;
  logic [31:0] Hi_OUT, Lo_OUT;

  hilo_muldiv_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .MthiEn(MthiEn), .MtloEn(MtloEn), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Hi_OUT(Hi_OUT), .Lo_OUT(Lo_OUT)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: architectural results from ordinary 64-bit arithmetic.
  task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, sp;
    logic        [63:0] acc;
    int sa32, sb32;
    sa   = $signed({{32{a[31]}}, a});
    sbv  = $signed({{32{b[31]}}, b});
    sp   = sa * sbv;
    acc  = {m_hi, m_lo};
    sa32 = a;
    sb32 = b;
    case (op)
      3'd0: {m_hi, m_lo} = sp;
      3'd1: {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
      3'd2: {m_hi, m_lo} = acc + sp;
      3'd3: {m_hi, m_lo} = acc - sp;
      3'd4, 3'd5: begin
        if (b == 0) begin
          m_lo = 32'hFFFF_FFFF;
          m_hi = a;
        end else if (op == 3'd5) begin
          m_lo = a / b;
          m_hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = 32'd0;
        end else begin
          m_lo = sa32 / sb32;
          m_hi = sa32 % sb32;
        end
      end
      default: ;
    endcase
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_hi"}, {32'd0, Hi_OUT}, {32'd0, e.hi});
          chk({e.tag, "_lo"}, {32'd0, Lo_OUT}, {32'd0, e.lo});
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where Done is visible (or the
  // negedge after a reset release), so a following call issues back-to-back.
  // inject: 0 none, 1 Start+mthi in cycle 10, 2 reset in cycle 15.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mh, input logic ml, input logic [31:0] wd,
                       input int inject, input string tag);
    int  busy_n;
    bit  seen;
    Start = 1'b1; Op = op; A = a; B = b;
    MthiEn = mh; MtloEn = ml; WrData = wd;
    if (mh) m_hi = wd;
    if (ml) m_lo = wd;
    if (inject != 2) begin
      ref_op(op, a, b);
      sb.push_back('{m_hi, m_lo, tag});
    end
    busy_n = 0;
    seen   = 0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge Clk);
      Start = 1'b0; MthiEn = 1'b0; MtloEn = 1'b0;
      if (Done === 1'b1) begin
        seen = 1;
        // Busy spans the 33 cycles after E0; Done is seen in the 34th.
        chk({tag, "_done_latency"}, k, 34);
        chk({tag, "_busy_cycles"}, busy_n, 33);
      end else if (Busy === 1'b1) begin
        busy_n++;
      end
      if (inject == 1 && k == 10) begin
        Start = 1'b1; Op = 3'd1; A = $urandom; B = $urandom;
        MthiEn = 1'b1; WrData = 32'hDEAD_BEEF;
      end
      if (inject == 2 && k == 15) begin
        Rst = 1'b1;
        #1;
        chk({tag, "_rst_busy"}, Busy, 0);
        chk({tag, "_rst_done"}, Done, 0);
        chk({tag, "_rst_hi"}, Hi_OUT, 0);
        chk({tag, "_rst_lo"}, Lo_OUT, 0);
        m_hi = '0;
        m_lo = '0;
        @(negedge Clk);
        Rst = 1'b0;
        return;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic mt(input logic mh, input logic ml, input logic [31:0] wd, input string tag);
    @(negedge Clk);
    MthiEn = mh; MtloEn = ml; WrData = wd;
    if (mh) m_hi = wd;
    if (ml) m_lo = wd;
    @(negedge Clk);
    MthiEn = 1'b0; MtloEn = 1'b0;
    chk({tag, "_hi"}, Hi_OUT, m_hi);
    chk({tag, "_lo"}, Lo_OUT, m_lo);
  endtask

  function automatic logic [31:0] pick(input bit zero_bias);
    case ($urandom_range(0, zero_bias ? 5 : 4))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 20));
      5:       return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  initial begin : stim
    logic [31:0] ra, rb, rwd;
    logic [2:0]  rop;
    bit          rmt;
    Rst = 1'b1; Start = 0; Op = 0; A = 0; B = 0;
    MthiEn = 0; MtloEn = 0; WrData = 0;
    repeat (3) @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    chk("reset_hi", Hi_OUT, 0);
    chk("reset_lo", Lo_OUT, 0);
    Rst = 1'b0;
    @(negedge Clk);

    do_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0, "mult_m2x3");
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0, "multu_m2x3");
    mt(1, 0, 32'd0, "mthi0");
    mt(0, 1, 32'd10, "mtlo10");
    @(negedge Clk);
    do_op(3'd2, 32'd4, 32'd5, 0, 0, 0, 0, "madd_4x5");
    do_op(3'd3, 32'd7, 32'd7, 0, 0, 0, 0, "msub_7x7");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, "div_m7_2");
    do_op(3'd5, 32'd7, 32'd2, 0, 0, 0, 0, "divu_7_2");
    do_op(3'd5, 32'd5, 32'd0, 0, 0, 0, 0, "divu_5_0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, "div_ovf");
    do_op(3'd0, 32'h0001_2345, 32'hFFFF_FFF0, 0, 0, 0, 1, "mult_busy_ignore");
    do_op(3'd4, 32'd100, 32'd7, 0, 0, 0, 2, "div_reset");
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0, "multu_after_rst");
    do_op(3'd2, 32'd3, 32'hFFFF_FFFD, 1, 1, 32'd100, 0, "madd_with_mt");

    // Reserved op code: never busy, but the accompanying mtlo still lands.
    @(negedge Clk);
    Start = 1'b1; Op = 3'd6; MtloEn = 1'b1; WrData = 32'h1234_5678; m_lo = WrData;
    @(negedge Clk);
    Start = 1'b0; MtloEn = 1'b0;
    chk("bad_op_busy", Busy, 0);
    chk("bad_op_mtlo", Lo_OUT, m_lo);
    @(negedge Clk);
    chk("bad_op_stays_idle", Busy, 0);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 5));
      ra  = pick(0);
      rb  = pick(rop[2]);
      rmt = ($urandom_range(0, 3) == 0);
      rwd = $urandom;
      if ($urandom_range(0, 2) == 0) @(negedge Clk);
      do_op(rop, ra, rb, rmt, rmt, rwd, 0, $sformatf("rnd%0d_op%0d", n, rop));
    end

    repeat (5) @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
